// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the memory port arbiter and the core's
// dcache side.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [1:0] WS_BYTE = 2'd0;
  localparam logic [1:0] WS_HALF = 2'd1;
  localparam logic [1:0] WS_WORD = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first set bit of req_i searching upward from
// start_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every output and temporary gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    valid_o = |req_i;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_i) + k) % N;
      if (!found && req_i[j]) begin
        idx_o = j[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port requester-to-memory arbiter: one transaction in flight, latched
// request payload, registered response data and one-hot completion pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      port_req,
  input  logic [NPORTS-1:0]      port_wr,
  input  logic [2*NPORTS-1:0]    port_ws,
  input  logic [AW*NPORTS-1:0]   port_addr,
  input  logic [DW*NPORTS-1:0]   port_wdata,
  output logic [DW-1:0]          port_rdata,
  output logic [NPORTS-1:0]      port_rdy,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic [1:0]             mem_ws,
  output logic                   mem_wr,
  output logic                   mem_req,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   mem_rdy,
  output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_idx,
  output logic                   busy
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      ws_q, ws_d;
  logic            wr_q, wr_d;
  logic            req_q, req_d;
  logic [NPORTS-1:0] rdy_q, rdy_d;

  logic [IW-1:0]   pick_start;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  // Fixed priority is round-robin search pinned to start at port 0.
  assign pick_start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;

  rr_pick #(
    .N  (NPORTS),
    .IW (IW)
  ) u_pick (
    .req_i   (port_req),
    .start_i (pick_start),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ws_d     = ws_q;
    wr_d     = wr_q;
    req_d    = req_q;
    rdy_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = port_addr[int'(pick_idx)*AW +: AW];
          wdata_d = port_wdata[int'(pick_idx)*DW +: DW];
          ws_d    = port_ws[int'(pick_idx)*2 +: 2];
          wr_d    = port_wr[pick_idx];
          req_d   = 1'b1;
          state_d = BUSY;
          if (ARB_MODE == ARB_RR)
            rr_ptr_d = (int'(pick_idx) == NPORTS - 1) ? '0 : pick_idx + 1'b1;
        end
      end
      BUSY: begin
        if (mem_rdy) begin
          rdata_d        = mem_rdata;
          rdy_d[grant_q] = 1'b1;
          req_d          = 1'b0;
          wr_d           = 1'b0;
          state_d        = DONE;
        end
      end
      // No grant here: a requester still holding req for the transaction
      // just completed must not be served twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ws_q     <= '0;
      wr_q     <= 1'b0;
      req_q    <= 1'b0;
      rdy_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ws_q     <= ws_d;
      wr_q     <= wr_d;
      req_q    <= req_d;
      rdy_q    <= rdy_d;
    end
  end

  assign port_rdata = rdata_q;
  assign port_rdy   = rdy_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_ws     = ws_q;
  assign mem_wr     = wr_q;
  assign mem_req    = req_q;
  assign grant_idx  = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: 2-port round-robin, 2-port fixed priority and 4-port
// round-robin instances sharing one clock and reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance a: NPORTS=2, round-robin
  logic [1:0]  a_req, a_wr, a_rdy, a_mws;
  logic [3:0]  a_ws;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        a_mwr, a_mreq, a_mrdy, a_gnt, a_busy;

  // Instance b: NPORTS=2, fixed priority
  logic [1:0]  b_req, b_wr, b_rdy, b_mws;
  logic [3:0]  b_ws;
  logic [63:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic        b_mwr, b_mreq, b_mrdy, b_gnt, b_busy;

  // Instance c: NPORTS=4, round-robin
  logic [3:0]   c_req, c_wr, c_rdy;
  logic [7:0]   c_ws;
  logic [127:0] c_addr, c_wdata;
  logic [31:0]  c_rdata, c_maddr, c_mwdata, c_mrdata;
  logic [1:0]   c_mws, c_gnt;
  logic         c_mwr, c_mreq, c_mrdy, c_busy;

  mem_port_arbiter #(.NPORTS(2), .AW(32), .DW(32), .ARB_MODE(0)) u_a (
    .clock(clk), .reset(rst_n), .port_req(a_req), .port_wr(a_wr), .port_ws(a_ws),
    .port_addr(a_addr), .port_wdata(a_wdata), .port_rdata(a_rdata), .port_rdy(a_rdy),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_ws(a_mws), .mem_wr(a_mwr),
    .mem_req(a_mreq), .mem_rdata(a_mrdata), .mem_rdy(a_mrdy), .grant_idx(a_gnt), .busy(a_busy));

  mem_port_arbiter #(.NPORTS(2), .AW(32), .DW(32), .ARB_MODE(1)) u_b (
    .clock(clk), .reset(rst_n), .port_req(b_req), .port_wr(b_wr), .port_ws(b_ws),
    .port_addr(b_addr), .port_wdata(b_wdata), .port_rdata(b_rdata), .port_rdy(b_rdy),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_ws(b_mws), .mem_wr(b_mwr),
    .mem_req(b_mreq), .mem_rdata(b_mrdata), .mem_rdy(b_mrdy), .grant_idx(b_gnt), .busy(b_busy));

  mem_port_arbiter #(.NPORTS(4), .AW(32), .DW(32), .ARB_MODE(0)) u_c (
    .clock(clk), .reset(rst_n), .port_req(c_req), .port_wr(c_wr), .port_ws(c_ws),
    .port_addr(c_addr), .port_wdata(c_wdata), .port_rdata(c_rdata), .port_rdy(c_rdy),
    .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_ws(c_mws), .mem_wr(c_mwr),
    .mem_req(c_mreq), .mem_rdata(c_mrdata), .mem_rdy(c_mrdy), .grant_idx(c_gnt), .busy(c_busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_wr = '0; a_ws = '0; a_addr = '0; a_wdata = '0; a_mrdata = '0; a_mrdy = 1'b0;
    b_req = '0; b_wr = '0; b_ws = '0; b_addr = '0; b_wdata = '0; b_mrdata = '0; b_mrdy = 1'b0;
    c_req = '0; c_wr = '0; c_ws = '0; c_addr = '0; c_wdata = '0; c_mrdata = '0; c_mrdy = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_mem_req",  a_mreq,  0);
    check("rst_mem_wr",   a_mwr,   0);
    check("rst_mem_addr", a_maddr, 0);
    check("rst_port_rdy", a_rdy,   0);
    check("rst_rdata",    a_rdata, 0);
    check("rst_busy",     a_busy,  0);
    check("rst_grant",    a_gnt,   0);
    check("rst_c_busy",   c_busy,  0);

    // Single read on port 1, memory answers 2 cycles after mem_req
    a_addr[32 +: 32] = 32'h100;
    a_req = 2'b10;
    step();
    check("rd_mem_req",  a_mreq,  1);
    check("rd_mem_addr", a_maddr, 32'h100);
    check("rd_mem_wr",   a_mwr,   0);
    check("rd_grant",    a_gnt,   1);
    check("rd_busy",     a_busy,  1);
    step();
    check("rd_wait_req", a_mreq,  1);
    check("rd_wait_rdy", a_rdy,   0);
    a_mrdy = 1'b1;
    a_mrdata = 32'hDEADBEEF;
    step();
    check("rd_rdy",      a_rdy,   2'b10);
    check("rd_rdata",    a_rdata, 32'hDEADBEEF);
    check("rd_done_req", a_mreq,  0);
    check("rd_done_busy", a_busy, 1);
    a_mrdy = 1'b0;
    step();
    check("rd_idle_rdy",   a_rdy,   0);
    check("rd_no_regrant", a_mreq,  0);
    check("rd_idle_busy",  a_busy,  0);
    check("rd_rdata_hold", a_rdata, 32'hDEADBEEF);
    a_req = 2'b00;

    // Round-robin contention, zero-wait memory: grants 0,1,0,1
    a_mrdy = 1'b1;
    a_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      a_mrdata = 32'hA0 + i;
      step();
      check("rr_grant", a_gnt, i % 2);
      check("rr_req",   a_mreq, 1);
      step();
      check("rr_rdy",   a_rdy, (i % 2) ? 2'b10 : 2'b01);
      check("rr_rdata", a_rdata, 32'hA0 + i);
      step();
      check("rr_idle",  a_busy, 0);
    end
    a_req = 2'b00;
    a_mrdy = 1'b0;

    // Fixed priority: port 0 wins while it requests
    b_mrdy = 1'b1;
    b_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fx_grant", b_gnt, 0);
      step();
      check("fx_rdy", b_rdy, 2'b01);
      step();
    end
    b_req = 2'b10;
    step();
    check("fx_grant_p1", b_gnt, 1);
    step();
    check("fx_rdy_p1", b_rdy, 2'b10);
    step();
    b_req = 2'b00;
    b_mrdy = 1'b0;

    // Write passthrough: latched payload ignores later input changes
    a_addr[0 +: 32]  = 32'h20;
    a_wdata[0 +: 32] = 32'h1234;
    a_ws[1:0] = 2'd1;
    a_wr = 2'b01;
    a_req = 2'b01;
    step();
    check("wr_mem_wr",    a_mwr,    1);
    check("wr_mem_ws",    a_mws,    1);
    check("wr_mem_addr",  a_maddr,  32'h20);
    check("wr_mem_wdata", a_mwdata, 32'h1234);
    a_addr[0 +: 32]  = 32'h44;
    a_wdata[0 +: 32] = 32'hFFFF;
    a_ws[1:0] = 2'd2;
    a_wr = 2'b00;
    step();
    check("wr_hold_wr",    a_mwr,    1);
    check("wr_hold_ws",    a_mws,    1);
    check("wr_hold_addr",  a_maddr,  32'h20);
    check("wr_hold_wdata", a_mwdata, 32'h1234);
    a_mrdy = 1'b1;
    step();
    check("wr_done_wr", a_mwr, 0);
    check("wr_rdy",     a_rdy, 2'b01);
    a_req = 2'b00;
    a_mrdy = 1'b0;
    step();

    // Reset while BUSY: outputs drop asynchronously, stray mem_rdy ignored
    a_req = 2'b10;
    step();
    check("rb_mem_req", a_mreq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_async_req",  a_mreq,  0);
    check("rb_async_busy", a_busy,  0);
    check("rb_async_addr", a_maddr, 0);
    a_req = 2'b00;
    step();
    rst_n = 1'b1;
    a_mrdy = 1'b1;
    step();
    check("rb_stray_rdy",  a_rdy,  0);
    check("rb_stray_busy", a_busy, 0);
    step();
    check("rb_stray_req",  a_mreq, 0);
    a_mrdy = 1'b0;

    // Reset while DONE: port_rdy pulse is cut short asynchronously
    a_req = 2'b01;
    a_mrdy = 1'b1;
    step();
    step();
    check("rd_done_pulse", a_rdy, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_async_rdy", a_rdy, 0);
    a_req = 2'b00;
    a_mrdy = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // NPORTS=4 wrap: drive rr_ptr to 3, then ports 0 and 2 contend
    c_mrdy = 1'b1;
    c_req = 4'b0100;
    step();
    check("w4_grant2", c_gnt, 2);
    step();
    check("w4_rdy2", c_rdy, 4'b0100);
    step();
    c_req = 4'b0101;
    c_mrdata = 32'h55;
    step();
    check("w4_wrap_grant0", c_gnt, 0);
    step();
    check("w4_wrap_rdy0", c_rdy, 4'b0001);
    check("w4_rdata",     c_rdata, 32'h55);
    step();
    step();
    check("w4_then_grant2", c_gnt, 2);
    step();
    check("w4_then_rdy2", c_rdy, 4'b0100);
    step();
    c_req = 4'b0000;
    c_mrdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port requester-to-memory arbiter; successor to the single-core top-level memory plumbing.
- Merges N cache-style request ports (icache, dcache, extra cores/DMA) onto one memory port.
- Uses the core's req/rdy protocol on both sides: requester holds req plus payload until a one-cycle rdy pulse.
- Adds round-robin or fixed-priority arbitration, registered response data and a grant/busy status.

Parameters:
NPORTS, 2, number of requester ports (>=1)
AW, 32, address width
DW, 32, data width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
port_req  in  NPORTS  per-port request
port_wr  in  NPORTS  per-port write enable
port_ws  in  2*NPORTS  per-port write size (0=byte, 1=half, 2=word)
port_addr  in  AW*NPORTS  per-port address, port i at [i*AW +: AW]
port_wdata  in  DW*NPORTS  per-port write data
port_rdata  out  DW  registered read data, valid when port_rdy[i]=1
port_rdy  out  NPORTS  one-hot completion pulse
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ws  out  2  memory write size
mem_wr  out  1  memory write enable
mem_req  out  1  memory request
mem_rdata  in  DW  memory read data
mem_rdy  in  1  memory completion pulse
grant_idx  out  $clog2(NPORTS) (min 1)  index of port being served
busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - mem_req=0, mem_wr=0, mem_ws=0, mem_addr=0, mem_wdata=0.
  - port_rdy=0, port_rdata=0, busy=0.
- Reset mid-transaction aborts it; no port_rdy is issued; any outstanding mem_rdy after release is ignored (state IDLE).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any port_req bit is set, pick a winner, latch grant_idx and that port's addr/wdata/ws/wr into output registers, set mem_req=1, go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection:
  - ARB_MODE=0: first requesting index searching upward from rr_ptr, wrapping modulo NPORTS. On grant, rr_ptr = (winner+1) mod NPORTS, with wrap at NPORTS-1 going to 0.
  - ARB_MODE=1: lowest requesting index; rr_ptr is unused and held at 0.
- BUSY:
  - mem_* outputs hold the latched values, not live port inputs.
  - On mem_rdy=1: capture mem_rdata into port_rdata, set port_rdy[grant_idx]=1, clear mem_req and mem_wr, go to DONE.
- DONE: port_rdy pulses for exactly this one cycle, then state goes to IDLE. No new grant is made in DONE, so a requester still holding req for its completed transaction is never re-served.
- Latency:
  - port_req sampled high at edge t, so mem_req=1 from cycle t+1.
  - mem_rdy seen at edge t+k (k>=1), so port_rdy high in cycle t+k+1.
  - Arbiter is back in IDLE at cycle t+k+2.
  - Minimum occupancy per transaction: 3 cycles.
- port_rdata keeps its last value outside rdy pulses. Write transactions also capture mem_rdata; requesters ignore it.
- A requester dropping req while BUSY is a protocol violation. The transaction still completes and port_rdy is still pulsed.
- NPORTS=1 degenerates to a registered pass-through with the same latency.
- No port is ever granted while its port_req bit is 0.
- Round-robin guarantee: each requesting port is served within NPORTS grants.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - ARB_RR=0 and ARB_FIXED=1 constants;
  - WS_BYTE/WS_HALF/WS_WORD encodings, shared with the core's dcache side.
- Sub-module rr_pick: combinational. Takes a req vector and a start pointer; outputs a valid flag and the winner index. Both modes use it; fixed mode ties the pointer to 0.

Test Plan:
- Single read: port1 req, addr=0x100; memory returns 0xDEADBEEF with mem_rdy 2 cycles after mem_req -> mem_addr=0x100 and mem_wr=0 while BUSY; port_rdy=2'b10 for one cycle with port_rdata=0xDEADBEEF; no second grant while req is still high in DONE.
- Contention, round-robin: both ports hold req continuously, zero-wait memory -> grant sequence 0,1,0,1; port_rdy alternates 01,10; each transaction takes 3 cycles.
- Contention, ARB_MODE=1: both ports hold req -> port 0 is granted every transaction; port 1 is granted only after port 0 drops req.
- Write passthrough: port0 wr=1, ws=1, addr=0x20, wdata=0x1234 -> mem_wr=1, mem_ws=1, mem_addr=0x20, mem_wdata=0x1234 held stable even if port0 inputs change during BUSY.
- Reset mid-transaction: reset=0 while BUSY -> mem_req and port_rdy drop to 0 asynchronously; after release, a stray mem_rdy=1 produces no port_rdy and state stays IDLE.
- Wrap with NPORTS=4, round-robin: rr_ptr=3, requests on ports 0 and 2 -> port 0 granted, then port 2.
